// File: rtl/y86_regfile_pkg.sv
// Shared Y86-64 register IDs, instruction codes and ID helpers.
// Optional feature macro (used by the register file): WB_BYPASS_EN.
package y86_regfile_pkg;

    typedef logic [3:0] reg_id_t;

    localparam reg_id_t RNONE = 4'hF;
    localparam reg_id_t RSP   = 4'h4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // True when id selects storage slot idx; RNONE and out-of-range IDs never match.
    function automatic logic id_hit(input reg_id_t id, input int idx);
        return id == reg_id_t'(idx);
    endfunction

endpackage

// File: rtl/y86_regfile_scoreboard.sv
// Pending-write counters per register and RAW/overflow stall logic.
// With WB_BYPASS_EN, a source whose pending writes all retire this cycle does not stall.
module y86_regfile_scoreboard
    import y86_regfile_pkg::*;
#(
    parameter int NREGS = 15,
    parameter int CNT_W = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_d_valid,
    input  reg_id_t i_srcA,
    input  reg_id_t i_srcB,
    input  reg_id_t i_dstE,
    input  reg_id_t i_dstM,
    input  logic    i_w_valid,
    input  reg_id_t i_w_dstE,
    input  reg_id_t i_w_dstM,
    output logic    o_stall,
    output logic    o_issue
);

    localparam int CW2 = CNT_W + 2;
    localparam logic [CW2-1:0] MAXC = CW2'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] r_cnt    [NREGS];
    logic [CNT_W-1:0] w_next   [NREGS];
    logic [1:0]       w_inc    [NREGS];
    logic [1:0]       w_ret    [NREGS];
    logic [CW2-1:0]   w_sum    [NREGS];
    logic [NREGS-1:0] w_byp;
    logic [NREGS-1:0] w_uflow;
    logic             w_hazA;
    logic             w_hazB;
    logic             w_ovf;

    // Per-register increments, retirements, hazards and next counter values.
    always_comb begin
        w_hazA  = 1'b0;
        w_hazB  = 1'b0;
        w_ovf   = 1'b0;
        w_byp   = '0;
        w_uflow = '0;
        o_stall = 1'b0;
        o_issue = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            w_inc[i] = {1'b0, id_hit(i_dstE, i)} + {1'b0, id_hit(i_dstM, i)};
            w_ret[i] = i_w_valid ?
                ({1'b0, id_hit(i_w_dstE, i)} + {1'b0, id_hit(i_w_dstM, i)}) : 2'd0;
`ifdef WB_BYPASS_EN
            w_byp[i] = CW2'(r_cnt[i]) == CW2'(w_ret[i]);
`else
            w_byp[i] = 1'b0;
`endif
            if (id_hit(i_srcA, i) && r_cnt[i] != '0 && !w_byp[i])
                w_hazA = 1'b1;
            if (id_hit(i_srcB, i) && r_cnt[i] != '0 && !w_byp[i])
                w_hazB = 1'b1;
            if (w_inc[i] != 2'd0 && (CW2'(r_cnt[i]) + CW2'(w_inc[i])) > MAXC)
                w_ovf = 1'b1;
        end
        o_stall = i_d_valid & (w_hazA | w_hazB | w_ovf);
        o_issue = i_d_valid & ~o_stall;
        for (int i = 0; i < NREGS; i++) begin
            w_sum[i]   = CW2'(r_cnt[i]) + (o_issue ? CW2'(w_inc[i]) : CW2'(0));
            w_uflow[i] = w_sum[i] < CW2'(w_ret[i]);
            w_next[i]  = w_uflow[i] ? '0 : CNT_W'(w_sum[i] - CW2'(w_ret[i]));
        end
    end

    // Counter state; reset drops every pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) r_cnt[i] <= w_next[i];
        end
    end

    // A retirement with no matching issue is a pipeline protocol error.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) w_uflow == '0);

endmodule

// File: rtl/y86_regfile_sb.sv
// Y86-64 register file: storage, registered read ports, write ports, snapshot.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data to the reads.
module y86_regfile_sb
    import y86_regfile_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int NREGS     = 15,
    parameter int CNT_W     = 2,
    parameter int RESET_IDX = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    d_valid,
    input  logic [3:0]              d_srcA,
    input  logic [3:0]              d_srcB,
    input  logic [3:0]              d_dstE,
    input  logic [3:0]              d_dstM,
    output logic                    d_stall,
    output logic [DATA_W-1:0]       d_valA,
    output logic [DATA_W-1:0]       d_valB,
    output logic                    d_rvalid,
    input  logic                    w_valid,
    input  logic [3:0]              w_dstE,
    input  logic [DATA_W-1:0]       w_valE,
    input  logic [3:0]              w_dstM,
    input  logic [DATA_W-1:0]       w_valM,
    output logic [NREGS*DATA_W-1:0] reg_flat
);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] w_rdA;
    logic [DATA_W-1:0] w_rdB;
    logic              w_issue;

    y86_regfile_scoreboard #(
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .i_d_valid (d_valid),
        .i_srcA    (d_srcA),
        .i_srcB    (d_srcB),
        .i_dstE    (d_dstE),
        .i_dstM    (d_dstM),
        .i_w_valid (w_valid),
        .i_w_dstE  (w_dstE),
        .i_w_dstM  (w_dstM),
        .o_stall   (d_stall),
        .o_issue   (w_issue)
    );

    // Read mux; bypass lets valM override valE for a retiring destination.
    always_comb begin
        w_rdA = '0;
        w_rdB = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (id_hit(d_srcA, i)) w_rdA = r_regs[i];
            if (id_hit(d_srcB, i)) w_rdB = r_regs[i];
`ifdef WB_BYPASS_EN
            if (w_valid && id_hit(d_srcA, i) && id_hit(w_dstE, i)) w_rdA = w_valE;
            if (w_valid && id_hit(d_srcB, i) && id_hit(w_dstE, i)) w_rdB = w_valE;
            if (w_valid && id_hit(d_srcA, i) && id_hit(w_dstM, i)) w_rdA = w_valM;
            if (w_valid && id_hit(d_srcB, i) && id_hit(w_dstM, i)) w_rdB = w_valM;
`endif
        end
    end

    // Register storage; on a shared destination the memory result wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= (RESET_IDX != 0) ? DATA_W'(i) : '0;
        end else if (w_valid) begin
            for (int i = 0; i < NREGS; i++) begin
                if (id_hit(w_dstM, i))
                    r_regs[i] <= w_valM;
                else if (id_hit(w_dstE, i))
                    r_regs[i] <= w_valE;
            end
        end
    end

    // Registered read ports, updated only when decode issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valA   <= '0;
            d_valB   <= '0;
            d_rvalid <= 1'b0;
        end else begin
            d_rvalid <= w_issue;
            if (w_issue) begin
                d_valA <= w_rdA;
                d_valB <= w_rdB;
            end
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
        assign reg_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
    end

endmodule

// File: tb/tb_y86_regfile_sb.sv
// Directed bench for y86_regfile_sb with a read-data scoreboard queue.
// Follows WB_BYPASS_EN when the build defines it.
module tb_y86_regfile_sb;

    localparam int DW = 64;
    localparam int NR = 15;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             d_valid;
    logic [3:0]       d_srcA, d_srcB, d_dstE, d_dstM;
    logic             d_stall;
    logic [DW-1:0]    d_valA, d_valB;
    logic             d_rvalid;
    logic             w_valid;
    logic [3:0]       w_dstE, w_dstM;
    logic [DW-1:0]    w_valE, w_valM;
    logic [NR*DW-1:0] reg_flat;

    exp_t          exp_q[$];
    logic [DW-1:0] m_regs [NR];
    int            n_tot  = 0;
    int            n_fail = 0;

    y86_regfile_sb #(
        .DATA_W    (DW),
        .NREGS     (NR),
        .CNT_W     (2),
        .RESET_IDX (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d_valid  (d_valid),
        .d_srcA   (d_srcA),
        .d_srcB   (d_srcB),
        .d_dstE   (d_dstE),
        .d_dstM   (d_dstM),
        .d_stall  (d_stall),
        .d_valA   (d_valA),
        .d_valB   (d_valB),
        .d_rvalid (d_rvalid),
        .w_valid  (w_valid),
        .w_dstE   (w_dstE),
        .w_valE   (w_valE),
        .w_dstM   (w_dstM),
        .w_valM   (w_valM),
        .reg_flat (reg_flat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_tot++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] getreg(input int i);
        return reg_flat[i*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] mread(input logic [3:0] id, input logic wv,
                                            input logic [3:0] wde, input logic [DW-1:0] wve,
                                            input logic [3:0] wdm, input logic [DW-1:0] wvm);
        if (int'(id) >= NR) return '0;
`ifdef WB_BYPASS_EN
        if (wv && wdm == id) return wvm;
        if (wv && wde == id) return wve;
`endif
        return m_regs[id];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = DW'(i);
        exp_q.delete();
    endtask

    task automatic step(input string tag, input logic v,
                        input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic wv, input logic [3:0] wde, input logic [DW-1:0] wve,
                        input logic [3:0] wdm, input logic [DW-1:0] wvm,
                        input logic xs);
        logic issued;
        exp_t e;
        @(negedge clk);
        d_valid = v;   d_srcA = sa;  d_srcB = sb;
        d_dstE  = de;  d_dstM = dm;
        w_valid = wv;  w_dstE = wde; w_valE = wve;
        w_dstM  = wdm; w_valM = wvm;
        #1;
        chk({tag, ":stall"}, DW'(d_stall), DW'(xs));
        issued = v && !xs;
        if (issued)
            exp_q.push_back('{mread(sa, wv, wde, wve, wdm, wvm),
                              mread(sb, wv, wde, wve, wdm, wvm)});
        @(posedge clk);
        if (wv) begin
            if (int'(wde) < NR) m_regs[wde] = wve;
            if (int'(wdm) < NR) m_regs[wdm] = wvm;
        end
        #1;
        chk({tag, ":rvalid"}, DW'(d_rvalid), DW'(issued));
        if (d_rvalid) begin
            if (exp_q.size() == 0) begin
                chk({tag, ":unexpected_read"}, DW'(d_rvalid), '0);
            end else begin
                e = exp_q.pop_front();
                chk({tag, ":valA"}, d_valA, e.a);
                chk({tag, ":valB"}, d_valB, e.b);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        d_valid = 0; d_srcA = 4'hF; d_srcB = 4'hF; d_dstE = 4'hF; d_dstM = 4'hF;
        w_valid = 0; w_dstE = 4'hF; w_dstM = 4'hF; w_valE = '0; w_valM = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valA", d_valA, '0);
        chk("rst_valB", d_valB, '0);
        chk("rst_rvalid", DW'(d_rvalid), '0);
        chk("rst_stall", DW'(d_stall), '0);
        chk("rst_reg3", getreg(3), 64'd3);
        chk("rst_reg14", getreg(14), 64'd14);
        @(negedge clk);
        rst = 1'b0;

        // Basic registered read
        step("rd_3_14", 1, 4'd3, 4'd14, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 0, 0);
        chk("rd_valA_3", d_valA, 64'd3);
        chk("rd_valB_14", d_valB, 64'd14);

        // RAW hazard on reg 2
        step("iss_dst2", 1, 4'hF, 4'hF, 4'd2, 4'hF, 0, 4'hF, 0, 4'hF, 0, 0);
        step("raw_stall", 1, 4'd2, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1);
`ifdef WB_BYPASS_EN
        step("raw_bypass", 1, 4'd2, 4'hF, 4'hF, 4'hF, 1, 4'd2, 64'h55, 4'hF, 0, 0);
`else
        step("raw_wb_cycle", 1, 4'd2, 4'hF, 4'hF, 4'hF, 1, 4'd2, 64'h55, 4'hF, 0, 1);
        step("raw_after_wb", 1, 4'd2, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 0, 0);
`endif
        chk("raw_valA_55", d_valA, 64'h55);

        // popq %rsp: both destinations on reg 4, valM wins
        step("pop_issue", 1, 4'hF, 4'hF, 4'd4, 4'd4, 0, 4'hF, 0, 4'hF, 0, 0);
        step("pop_wb", 0, 4'hF, 4'hF, 4'hF, 4'hF, 1, 4'd4, 64'h100, 4'd4, 64'hBEEF, 0);
        chk("pop_reg4", getreg(4), 64'hBEEF);
        step("pop_read", 1, 4'd4, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 0, 0);
        chk("pop_valA", d_valA, 64'hBEEF);

        // Counter saturation on reg 5
        for (int k = 0; k < 3; k++)
            step("sat_issue", 1, 4'hF, 4'hF, 4'd5, 4'hF, 0, 4'hF, 0, 4'hF, 0, 0);
        step("sat_full", 1, 4'hF, 4'hF, 4'd5, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1);
        step("sat_wb", 1, 4'hF, 4'hF, 4'd5, 4'hF, 1, 4'd5, 64'h77, 4'hF, 0, 1);
        step("sat_clear", 1, 4'hF, 4'hF, 4'd5, 4'hF, 0, 4'hF, 0, 4'hF, 0, 0);

        // Every counter nonzero; reg 7 gets two
        for (int i = 0; i < NR; i++) begin
            if (i != 5 && i != 7)
                step("fill", 1, 4'hF, 4'hF, 4'(i), 4'hF, 0, 4'hF, 0, 4'hF, 0, 0);
        end
        step("fill7", 1, 4'hF, 4'hF, 4'd7, 4'd7, 0, 4'hF, 0, 4'hF, 0, 0);
        step("busy_src9", 1, 4'hF, 4'd9, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 0, 1);
        step("rnone_rd", 1, 4'hF, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 0, 0);
        chk("rnone_valA", d_valA, '0);
        chk("rnone_valB", d_valB, '0);

        // Asynchronous reset mid-run
        @(negedge clk);
        rst = 1'b1;
        d_valid = 1'b0;
        w_valid = 1'b0;
        #1;
        chk("mrst_rvalid", DW'(d_rvalid), '0);
        chk("mrst_valA", d_valA, '0);
        chk("mrst_reg4", getreg(4), 64'd4);
        chk("mrst_reg2", getreg(2), 64'd2);
        chk("mrst_reg5", getreg(5), 64'd5);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_rd", 1, 4'd7, 4'd5, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 0, 0);
        step("post_rst_rd2", 1, 4'd4, 4'd9, 4'hF, 4'hF, 0, 4'hF, 0, 4'hF, 0, 0);
        chk("post_rst_valA", d_valA, 64'd4);

        $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
        $finish;
    end

endmodule
